// File: rtl/count_mon_pkg.sv
// Shared state encoding and default parameters for the counter monitor.
package count_mon_pkg;

    // Encoding 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_ERR_W    = 8;
    localparam int DEF_LOCK_CNT = 2;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/count_monitor.sv
// Checks a free-running counter and its /2 and /4 taps: locks onto a clean
// +1 sequence, then records step errors, divider mismatches and wraps.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             div_2,
    input  logic             div_4,
    output logic             locked,
    output logic             fault,
    output logic             div_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0] last_bad
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    state_t           state, state_next;
    logic [RUN_W-1:0] run, run_next;
    logic [WIDTH-1:0] prev;

    logic good, div_bad, in_lock, step_err, div_hit, wrap_hit, err_inc;

    // Errors and wraps only count while enabled and locked; with en low the
    // FSM is heading to IDLE and statistics hold.
    assign good     = (cnt_in == prev + WIDTH'(1));
    assign div_bad  = (div_2 != cnt_in[0]) || (div_4 != cnt_in[1]);
    assign in_lock  = en && (state == LOCK);
    assign step_err = in_lock && !good;
    assign div_hit  = in_lock && div_bad;
    assign wrap_hit = in_lock && (prev == '1) && (cnt_in == '0);
    assign err_inc  = step_err || div_hit;

    // Next-state logic: IDLE -> SYNC on enable, SYNC counts good steps up to
    // LOCK_CNT, LOCK drops back to SYNC on the first bad step.
    always_comb begin
        state_next = state;
        run_next   = run;
        if (!en) begin
            state_next = IDLE;
            run_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = SYNC;
                    run_next   = '0;
                end
                SYNC: begin
                    if (good) begin
                        if (run + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
                            state_next = LOCK;
                            run_next   = '0;
                        end else begin
                            run_next = run + RUN_W'(1);
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCK: begin
                    if (!good) begin
                        state_next = SYNC;
                        run_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    // State, step history and the registered locked flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            run    <= '0;
            prev   <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_next;
            run    <= run_next;
            prev   <= cnt_in;
            locked <= (state_next == LOCK);
        end
    end

    // Sticky error flags and the value of the latest bad step; clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault    <= 1'b0;
            div_err  <= 1'b0;
            last_bad <= '0;
        end else if (clr) begin
            fault    <= 1'b0;
            div_err  <= 1'b0;
            last_bad <= '0;
        end else begin
            if (step_err) begin
                fault    <= 1'b1;
                last_bad <= cnt_in;
            end
            if (div_hit)
                div_err <= 1'b1;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clr),
        .count (err_cnt)
    );

    sat_counter #(.W(ERR_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap_hit),
        .clr   (clr),
        .count (wrap_cnt)
    );

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: a reference model pushes the
// expected output vector per driven cycle, a negedge monitor pops/compares,
// and each scenario task adds direct checks of the headline values.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst, en, clr, div_2, div_4;
    logic [3:0] cnt_in;
    logic       locked, fault, div_err;
    logic [7:0] err_cnt, wrap_cnt;
    logic [3:0] last_bad;

    count_monitor #(.WIDTH(4), .ERR_W(8), .LOCK_CNT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .cnt_in   (cnt_in),
        .div_2    (div_2),
        .div_4    (div_4),
        .locked   (locked),
        .fault    (fault),
        .div_err  (div_err),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .last_bad (last_bad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // reference model state
    int         m_state, m_run, m_err, m_wrap;
    logic       m_fault, m_div, m_locked;
    logic [3:0] m_prev, m_last;
    logic [3:0] c;              // last counter value driven

    logic [22:0] sb[$];
    logic [22:0] obs;
    assign obs = {locked, fault, div_err, err_cnt, wrap_cnt, last_bad};

    task automatic model_reset();
        m_state = 0; m_run = 0; m_err = 0; m_wrap = 0;
        m_fault = 0; m_div = 0; m_locked = 0; m_prev = 0; m_last = 0;
        sb.delete();
    endtask

    // Drive one cycle, advance the model, queue its expectation.
    task automatic cyc(input logic e, input logic cl, input logic [3:0] v,
                       input logic d2, input logic d4);
        logic good, bad, dm, wr;
        int   ns;
        en = e; clr = cl; cnt_in = v; div_2 = d2; div_4 = d4;
        good = (v == 4'(m_prev + 4'd1));
        bad = 0; dm = 0; wr = 0;
        ns = m_state;
        if (!e) begin
            ns = 0; m_run = 0;
        end else if (m_state == 0) begin
            ns = 1; m_run = 0;
        end else if (m_state == 1) begin
            if (!good) m_run = 0;
            else if (m_run + 1 == 2) begin ns = 2; m_run = 0; end
            else m_run = m_run + 1;
        end else if (m_state == 2) begin
            bad = !good;
            dm  = (d2 != v[0]) || (d4 != v[1]);
            wr  = (m_prev == 4'hF) && (v == 4'h0);
            if (bad) begin ns = 1; m_run = 0; end
        end else begin
            ns = 0;
        end
        if (cl) begin
            m_err = 0; m_wrap = 0; m_fault = 0; m_div = 0; m_last = 0;
        end else begin
            if ((bad || dm) && m_err < 255) m_err = m_err + 1;
            if (wr && m_wrap < 255) m_wrap = m_wrap + 1;
            if (bad) begin m_fault = 1; m_last = v; end
            if (dm) m_div = 1;
        end
        m_prev = v; m_state = ns; m_locked = (ns == 2);
        sb.push_back({m_locked, m_fault, m_div, 8'(m_err), 8'(m_wrap), m_last});
        @(posedge clk); #1;
    endtask

    task automatic good_steps(input int n);
        for (int i = 0; i < n; i++) begin
            c = c + 4'd1;
            cyc(1'b1, 1'b0, c, c[0], c[1]);
        end
    endtask

    // Scoreboard: compare the full output vector after every driven edge.
    always @(negedge clk) begin
        logic [22:0] exp_v;
        if (sb.size() != 0) begin
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v)
                $display("FAIL scoreboard t=%0t got %h expected %h", $time, obs, exp_v);
            else
                passed++;
        end
    end

    task automatic test_reset();
        #2;
        checks++; if ({locked, fault, div_err} !== 3'b000) $display("FAIL reset_flags got %b expected 000", {locked, fault, div_err}); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err got %0d expected 0", err_cnt); else passed++;
        checks++; if (wrap_cnt !== 8'd0) $display("FAIL reset_wrap got %0d expected 0", wrap_cnt); else passed++;
        checks++; if (last_bad !== 4'd0) $display("FAIL reset_last got %0d expected 0", last_bad); else passed++;
        #1 rst = 1'b0;
    endtask

    task automatic test_lock_wrap();
        c = 4'hF;
        good_steps(2);
        checks++; if (locked !== 1'b0) $display("FAIL lock_early got %b expected 0", locked); else passed++;
        good_steps(1);
        checks++; if (locked !== 1'b1) $display("FAIL lock_latency got %b expected 1", locked); else passed++;
        good_steps(32);
        checks++; if (wrap_cnt !== 8'd2) $display("FAIL wrap_cnt got %0d expected 2", wrap_cnt); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL clean_err got %0d expected 0", err_cnt); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL clean_fault got %b expected 0", fault); else passed++;
    endtask

    task automatic test_step_err();
        while (c != 4'd5) good_steps(1);
        c = 4'd7;
        cyc(1'b1, 1'b0, c, c[0], c[1]);
        checks++; if (err_cnt !== 8'd1) $display("FAIL step_err_cnt got %0d expected 1", err_cnt); else passed++;
        checks++; if (last_bad !== 4'd7) $display("FAIL step_last_bad got %0d expected 7", last_bad); else passed++;
        checks++; if (fault !== 1'b1) $display("FAIL step_fault got %b expected 1", fault); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL step_unlock got %b expected 0", locked); else passed++;
        good_steps(1);
        checks++; if (locked !== 1'b0) $display("FAIL relock_early got %b expected 0", locked); else passed++;
        good_steps(1);
        checks++; if (locked !== 1'b1) $display("FAIL relock got %b expected 1", locked); else passed++;
    endtask

    task automatic test_div_err();
        c = c + 4'd1;
        cyc(1'b1, 1'b1, c, c[0], c[1]);
        checks++; if ({fault, err_cnt} !== 9'd0) $display("FAIL clr_stats got %h expected 0", {fault, err_cnt}); else passed++;
        while (c != 4'hF) good_steps(1);
        for (int i = 0; i < 8; i++) begin
            c = c + 4'd1;
            cyc(1'b1, 1'b0, c, c[0], 1'b0);
        end
        checks++; if (err_cnt !== 8'd4) $display("FAIL div_err_cnt got %0d expected 4", err_cnt); else passed++;
        checks++; if (div_err !== 1'b1) $display("FAIL div_err_flag got %b expected 1", div_err); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL div_no_fault got %b expected 0", fault); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL div_locked got %b expected 1", locked); else passed++;
    endtask

    task automatic test_saturate();
        int nw;
        nw = 0;
        c = c + 4'd1;
        cyc(1'b1, 1'b1, c, c[0], c[1]);
        for (int i = 0; i < 301; i++) begin
            c = c + 4'd1;
            if (c == 4'd0) nw++;
            cyc(1'b1, 1'b0, c, ~c[0], c[1]);
            if (i == 299) begin
                checks++; if (err_cnt !== 8'd255) $display("FAIL sat_err got %0d expected 255", err_cnt); else passed++;
            end
        end
        checks++; if (err_cnt !== 8'd255) $display("FAIL sat_hold got %0d expected 255", err_cnt); else passed++;
        checks++; if (wrap_cnt !== 8'(nw)) $display("FAIL sat_wrap got %0d expected %0d", wrap_cnt, nw); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL sat_locked got %b expected 1", locked); else passed++;
    endtask

    task automatic test_clr_skip();
        logic [3:0] skip_v;
        c = c + 4'd2;
        cyc(1'b1, 1'b1, c, c[0], c[1]);
        checks++; if (err_cnt !== 8'd0) $display("FAIL clr_skip_err got %0d expected 0", err_cnt); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL clr_skip_fault got %b expected 0", fault); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL clr_skip_locked got %b expected 0", locked); else passed++;
        good_steps(2);
        c = c + 4'd2;
        skip_v = c;
        cyc(1'b1, 1'b0, c, c[0], c[1]);
        good_steps(2);
        checks++; if (locked !== 1'b1) $display("FAIL pre_en_drop got %b expected 1", locked); else passed++;
        c = c + 4'd1;
        cyc(1'b0, 1'b0, c, c[0], c[1]);
        checks++; if (locked !== 1'b0) $display("FAIL en_drop_locked got %b expected 0", locked); else passed++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL en_drop_err got %0d expected 1", err_cnt); else passed++;
        checks++; if (last_bad !== skip_v) $display("FAIL en_drop_last got %0d expected %0d", last_bad, skip_v); else passed++;
    endtask

    task automatic test_reset_mid();
        c = c + 4'd1;
        cyc(1'b1, 1'b0, c, c[0], c[1]);
        good_steps(2);
        checks++; if ({locked, err_cnt} !== {1'b1, 8'd1}) $display("FAIL pre_rst got %h expected 101", {locked, err_cnt}); else passed++;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if ({locked, fault, div_err} !== 3'b000) $display("FAIL rst_mid_flags got %b expected 000", {locked, fault, div_err}); else passed++;
        checks++; if ({err_cnt, wrap_cnt, last_bad} !== 20'd0) $display("FAIL rst_mid_stats got %h expected 0", {err_cnt, wrap_cnt, last_bad}); else passed++;
        #1 rst = 1'b0;
        model_reset();
        c = 4'hF;
        good_steps(2);
        checks++; if (locked !== 1'b0) $display("FAIL post_rst_early got %b expected 0", locked); else passed++;
        good_steps(1);
        checks++; if (locked !== 1'b1) $display("FAIL post_rst_lock got %b expected 1", locked); else passed++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; cnt_in = '0; div_2 = 1'b0; div_4 = 1'b0;
        model_reset();
        test_reset();
        test_lock_wrap();
        test_step_err();
        test_div_err();
        test_saturate();
        test_clr_skip();
        test_reset_mid();
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
